id_ex_fwd_stage: RTL and testbench

ID_EX_FWD_STAGE -- requirements
Module: id_ex_fwd_stage

---
 rtl/id_ex_fwd_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_fwd_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with bubble/hold control, load-use hazard detection
// and EX-stage operand forwarding select generation.
module id_ex_fwd_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_alusrc,
  input  logic [3:0]        id_aluop,
  input  logic [4:0]        exmem_rd,
  input  logic              exmem_regwrite,
  input  logic [4:0]        memwb_rd,
  input  logic              memwb_regwrite,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_alusrc,
  output logic [3:0]        ex_aluop,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              load_use_stall,
  output logic [15:0]       bubble_count
);

  logic [DATA_W-1:0] r_ex_rd1, r_ex_rd2, r_ex_imm;
  logic [4:0]        r_ex_rs1, r_ex_rs2, r_ex_rd;
  logic              r_ex_regwrite, r_ex_memread, r_ex_memwrite, r_ex_memtoreg, r_ex_alusrc;
  logic [3:0]        r_ex_aluop;
  logic [15:0]       r_bubble_count;
  logic              w_load_use;
  logic              w_bubble;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // EX/MEM wins over MEM/WB; x0 is hardwired zero so it is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs))
      return 2'b10;
    else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_load_use = r_ex_memread && (r_ex_rd != 5'd0) &&
                      ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));
  // Flush beats stall; stall beats a load-use bubble.
  assign w_bubble   = flush || (!stall && w_load_use);

  // ID -> EX stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_rd1       <= '0;
      r_ex_rd2       <= '0;
      r_ex_imm       <= '0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rd        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_memwrite  <= 1'b0;
      r_ex_memtoreg  <= 1'b0;
      r_ex_alusrc    <= 1'b0;
      r_ex_aluop     <= '0;
      r_bubble_count <= '0;
    end else if (w_bubble) begin
      r_ex_rd1       <= '0;
      r_ex_rd2       <= '0;
      r_ex_imm       <= '0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rd        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_memwrite  <= 1'b0;
      r_ex_memtoreg  <= 1'b0;
      r_ex_alusrc    <= 1'b0;
      r_ex_aluop     <= '0;
      r_bubble_count <= sat_inc(r_bubble_count);
    end else if (!stall) begin
      r_ex_rd1       <= id_rd1;
      r_ex_rd2       <= id_rd2;
      r_ex_imm       <= id_imm;
      r_ex_rs1       <= id_rs1;
      r_ex_rs2       <= id_rs2;
      r_ex_rd        <= id_rd;
      r_ex_regwrite  <= id_regwrite;
      r_ex_memread   <= id_memread;
      r_ex_memwrite  <= id_memwrite;
      r_ex_memtoreg  <= id_memtoreg;
      r_ex_alusrc    <= id_alusrc;
      r_ex_aluop     <= id_aluop;
    end
  end

  assign ex_rd1         = r_ex_rd1;
  assign ex_rd2         = r_ex_rd2;
  assign ex_imm         = r_ex_imm;
  assign ex_rs1         = r_ex_rs1;
  assign ex_rs2         = r_ex_rs2;
  assign ex_rd          = r_ex_rd;
  assign ex_regwrite    = r_ex_regwrite;
  assign ex_memread     = r_ex_memread;
  assign ex_memwrite    = r_ex_memwrite;
  assign ex_memtoreg    = r_ex_memtoreg;
  assign ex_alusrc      = r_ex_alusrc;
  assign ex_aluop       = r_ex_aluop;
  assign bubble_count   = r_bubble_count;
  assign load_use_stall = w_load_use;
  assign forward_a      = fwd_sel(r_ex_rs1);
  assign forward_b      = fwd_sel(r_ex_rs2);

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Directed bench for id_ex_fwd_stage: a reference model pushes expected ID/EX
// state into a queue each cycle, popped and compared after the clock edge.
module tb_id_ex_fwd_stage;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, mtr, as;
    logic [3:0]  op;
    logic [15:0] cnt;
  } st_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, stall;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
  logic [3:0]  id_aluop;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_regwrite, memwb_regwrite;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
  logic [3:0]  ex_aluop;
  logic [1:0]  forward_a, forward_b;
  logic        load_use_stall;
  logic [15:0] bubble_count;

  int   total = 0;
  int   bad   = 0;
  st_t  m;
  st_t  exp_q[$];

  always #5 clk = ~clk;

  id_ex_fwd_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .forward_a(forward_a), .forward_b(forward_b),
    .load_use_stall(load_use_stall), .bubble_count(bubble_count)
  );

  function automatic st_t dut_st();
    st_t s;
    s.rd1 = ex_rd1; s.rd2 = ex_rd2; s.imm = ex_imm;
    s.rs1 = ex_rs1; s.rs2 = ex_rs2; s.rd = ex_rd;
    s.rw = ex_regwrite; s.mr = ex_memread; s.mw = ex_memwrite;
    s.mtr = ex_memtoreg; s.as = ex_alusrc; s.op = ex_aluop;
    s.cnt = bubble_count;
    return s;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == rs) return 2'b10;
    if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_lus();
    return m.mr && (m.rd != 5'd0) && ((m.rd == id_rs1) || (m.rd == id_rs2));
  endfunction

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input string tag);
    check(tag, {131'd0, forward_a, forward_b, load_use_stall},
               {131'd0, exp_fwd(m.rs1), exp_fwd(m.rs2), exp_lus()});
  endtask

  task automatic cycle(input bit do_chk, input string tag);
    st_t e;
    st_t got;
    e = m;
    if (flush || (!stall && exp_lus())) begin
      e = '0;
      e.cnt = (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1;
    end else if (!stall) begin
      e.rd1 = id_rd1; e.rd2 = id_rd2; e.imm = id_imm;
      e.rs1 = id_rs1; e.rs2 = id_rs2; e.rd = id_rd;
      e.rw = id_regwrite; e.mr = id_memread; e.mw = id_memwrite;
      e.mtr = id_memtoreg; e.as = id_alusrc; e.op = id_aluop;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    if (do_chk) check(tag, dut_st(), got);
    m = got;
  endtask

  task automatic set_id(input logic [31:0] a, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic mr, input logic [3:0] op);
    id_rd1 = a; id_rd2 = ~a; id_imm = a ^ 32'h0F0F0F0F;
    id_rs1 = s1; id_rs2 = s2; id_rd = d;
    id_regwrite = 1'b1; id_memread = mr; id_memwrite = ~mr;
    id_memtoreg = mr; id_alusrc = op[0]; id_aluop = op;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    set_id(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 4'h0);
    id_regwrite = 1'b0; id_memwrite = 1'b0;
    exmem_rd = 5'd0; exmem_regwrite = 1'b1; memwb_rd = 5'd0; memwb_regwrite = 1'b1;
    m = '0;
    #2;
    check("reset_state", dut_st(), '0);
    chk_comb("reset_comb");
    #8 rst_n = 1'b1;

    // Basic load
    id_rd1 = 32'hDEADBEEF; id_rs1 = 5'd5; id_rd = 5'd7; id_regwrite = 1'b1;
    id_rs2 = 5'd6; id_aluop = 4'hA; id_alusrc = 1'b1; id_imm = 32'h1234;
    cycle(1, "load_basic");
    check("load_fields", {92'd0, ex_rd1, ex_rs1, ex_rd, ex_regwrite},
                         {92'd0, 32'hDEADBEEF, 5'd5, 5'd7, 1'b1});

    // Forwarding priority and x0
    exmem_rd = 5'd5; memwb_rd = 5'd5;
    #1 check("fwd_a_exmem", {134'd0, forward_a}, {134'd0, 2'b10});
    chk_comb("fwd_both_hit");
    exmem_regwrite = 1'b0;
    #1 check("fwd_a_memwb", {134'd0, forward_a}, {134'd0, 2'b01});
    memwb_rd = 5'd6; exmem_rd = 5'd6; exmem_regwrite = 1'b1;
    #1 chk_comb("fwd_b_exmem");
    exmem_regwrite = 1'b0;
    #1 chk_comb("fwd_b_memwb");
    set_id(32'h11111111, 5'd0, 5'd0, 5'd2, 1'b0, 4'h3);
    exmem_rd = 5'd0; exmem_regwrite = 1'b1; memwb_rd = 5'd0;
    cycle(1, "load_x0");
    check("fwd_x0", {132'd0, forward_a, forward_b}, 136'd0);

    // Load-use hazard
    set_id(32'hA5A5A5A5, 5'd1, 5'd2, 5'd3, 1'b1, 4'h5);
    cycle(1, "load_lw");
    id_rs1 = 5'd9; id_rs2 = 5'd3;
    #1 check("lus_hit", {135'd0, load_use_stall}, {135'd0, 1'b1});
    cycle(1, "lus_bubble");
    check("lus_count", {120'd0, bubble_count}, {120'd0, 16'd1});
    set_id(32'h22222222, 5'd4, 5'd4, 5'd0, 1'b1, 4'h6);
    cycle(1, "load_lw_x0");
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1 check("lus_x0", {135'd0, load_use_stall}, 136'd0);

    // Stall holds; forwarding tracks held indices
    set_id(32'h33333333, 5'd12, 5'd13, 5'd14, 1'b0, 4'h7);
    cycle(1, "load_pre_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id($urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 4'($urandom));
      cycle(1, "stall_hold");
    end
    exmem_rd = 5'd12; exmem_regwrite = 1'b1; memwb_rd = 5'd13; memwb_regwrite = 1'b1;
    #1 chk_comb("fwd_while_hold");
    check("fwd_hold_val", {132'd0, forward_a, forward_b}, {132'd0, 2'b10, 2'b01});
    flush = 1'b1;
    cycle(1, "flush_stall");
    check("flush_stall_cnt", {120'd0, bubble_count}, {120'd0, 16'd2});
    flush = 1'b0; stall = 1'b0;

    // Stall beats load-use: hold, no count
    set_id(32'h44444444, 5'd1, 5'd1, 5'd4, 1'b1, 4'h8);
    cycle(1, "load_lw2");
    id_rs1 = 5'd4; stall = 1'b1;
    #1 chk_comb("lus_under_stall");
    cycle(1, "stall_lus_hold");
    stall = 1'b0;
    cycle(1, "lus_after_stall");

    // Asynchronous reset between edges
    set_id(32'h55555555, 5'd7, 5'd8, 5'd9, 1'b1, 4'h9);
    cycle(1, "load_pre_rst");
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_st(), '0);
    m = '0;
    chk_comb("reset_comb_mid");
    #1 rst_n = 1'b1;
    cycle(1, "load_post_rst");

    // Saturation of bubble_count
    flush = 1'b1;
    while (m.cnt != 16'hFFFE) cycle(0, "flush_fill");
    check("cnt_fffe", {120'd0, bubble_count}, {120'd0, 16'hFFFE});
    cycle(1, "flush_sat1");
    cycle(1, "flush_sat2");
    check("cnt_sat", {120'd0, bubble_count}, {120'd0, 16'hFFFF});
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
